// File: rtl/regfile_pkg.sv
// Shared defaults and types for the WISC decode-stage register file.
package regfile_pkg;

  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefDepth   = 16;
  localparam bit          DefZeroReg = 1'b0;
  localparam int unsigned DefAw      = $clog2(DefDepth);

  typedef logic [DefAw-1:0]    addr_t;
  typedef logic [DefWidth-1:0] data_t;

endpackage

// File: rtl/register_nb.sv
// One enabled register with asynchronous active-high reset to zero.
module register_nb #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (en) begin
      state <= data_in;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = DefZeroReg
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr0,
  output logic [WIDTH-1:0] rd_data0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  output logic             addr_err
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  function automatic logic addr_ok(logic [AW-1:0] a);
    return {1'b0, a} < DepthW;
  endfunction

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] rd_mux0, rd_mux1;
  logic             addr_err_d, addr_err_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (ZERO_REG && i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_store
      logic wr_hit;
      assign wr_hit = wr_en && (wr_addr == AW'(i));

      register_nb #(
        .WIDTH (WIDTH)
      ) u_reg (
        .clk     (clk),
        .rst     (rst),
        .en      (wr_hit),
        .data_in (wr_data),
        .state   (regs[i])
      );
    end
  end

  // Addresses with no matching entry fall through to zero.
  always_comb begin
    rd_mux0 = '0;
    rd_mux1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr0 == AW'(i)) rd_mux0 = regs[i];
      if (rd_addr1 == AW'(i)) rd_mux1 = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp0, byp1;

  always_comb begin
    byp0 = wr_en && (wr_addr == rd_addr0) && addr_ok(rd_addr0) &&
           !(ZERO_REG && rd_addr0 == '0);
    byp1 = wr_en && (wr_addr == rd_addr1) && addr_ok(rd_addr1) &&
           !(ZERO_REG && rd_addr1 == '0);
    rd_data0 = byp0 ? wr_data : rd_mux0;
    rd_data1 = byp1 ? wr_data : rd_mux1;
  end
`else
  always_comb begin
    rd_data0 = rd_mux0;
    rd_data1 = rd_mux1;
  end
`endif

  always_comb begin
    addr_err_d = (wr_en && !addr_ok(wr_addr)) || !addr_ok(rd_addr0) || !addr_ok(rd_addr1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;

endmodule
